// File: rtl/cor_term_if.sv
// Character I/O bus between the processor's IN/OUT registers and the console terminal adapter.
// The master side is the processor; the slave side is cor_term.
interface cor_term_if;
  logic       io_rxd;
  logic       io_txd;
  logic [7:0] io_inpr;
  logic       io_fgiset;
  logic       io_fgi;
  logic [7:0] io_outr;
  logic       io_fgo;
  logic       io_fgoset;
  logic       io_overrun;
  logic       io_framerr;
  logic       io_clrerr;

  modport master (
    output io_rxd, io_fgi, io_outr, io_fgo, io_clrerr,
    input  io_txd, io_inpr, io_fgiset, io_fgoset, io_overrun, io_framerr
  );

  modport slave (
    input  io_rxd, io_fgi, io_outr, io_fgo, io_clrerr,
    output io_txd, io_inpr, io_fgiset, io_fgoset, io_overrun, io_framerr
  );
endinterface

// File: rtl/cor_term.sv
// Console terminal adapter: 8N1 serial receiver feeding the processor input register and
// serial transmitter draining the processor output register, with sticky overrun/framing flags.
module cor_term #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      io_clock,
  input  logic      io_reset_n,
  cor_term_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_FLUSH} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_WAIT} tx_state_t;

  logic            rxd_p0, rxd_p1;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [3:0]      rx_bits;
  logic [7:0]      rx_shift;
  logic [7:0]      inpr_q;
  logic            fgiset_q, overrun_q, framerr_q;

  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bits;
  logic [7:0]      tx_shift;
  logic            txd_q, fgoset_q;

  // Stage p0/p1: two-flop synchroniser; idles high so reset never fakes a start bit
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= bus.io_rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  // Receive FSM: mid-bit sampling of the synchronised line, delivery and error flags
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      inpr_q    <= '0;
      fgiset_q  <= 1'b0;
      overrun_q <= 1'b0;
      framerr_q <= 1'b0;
    end else begin
      fgiset_q <= 1'b0;
      // Clear first so a set event later in this block takes precedence
      if (bus.io_clrerr) begin
        overrun_q <= 1'b0;
        framerr_q <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          rx_cnt  <= '0;
          rx_bits <= '0;
          if (!rxd_p1) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_state <= rxd_p1 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt  <= '0;
            rx_bits <= rx_bits + 1'b1;
            if (rx_bits == 4'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            if (!rxd_p1) begin
              framerr_q <= 1'b1;
              rx_state  <= RX_FLUSH;
            end else if (!bus.io_fgi) begin
              inpr_q   <= rx_shift;
              fgiset_q <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              overrun_q <= 1'b1;
              rx_state  <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_FLUSH: if (rxd_p1) rx_state <= RX_IDLE;
        default:  rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge io_clock) begin
    if (rx_state == RX_DATA && rx_cnt == CNT_LAST) rx_shift <= {rxd_p1, rx_shift[7:1]};
  end

  // Transmit FSM: TX_WAIT holds off until the processor's flag update lands
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      txd_q    <= 1'b1;
      fgoset_q <= 1'b0;
    end else begin
      fgoset_q <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt  <= '0;
          tx_bits <= '0;
          if (!bus.io_fgo) begin
            txd_q    <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            txd_q    <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd7) begin
              txd_q    <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bits <= tx_bits + 1'b1;
              txd_q   <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            fgoset_q <= 1'b1;
            tx_state <= TX_WAIT;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_WAIT: if (bus.io_fgo) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge io_clock) begin
    if (tx_state == TX_IDLE && !bus.io_fgo)
      tx_shift <= bus.io_outr;
    else if (tx_state == TX_DATA && tx_cnt == CNT_LAST)
      tx_shift <= {1'b0, tx_shift[7:1]};
  end

  assign bus.io_txd     = txd_q;
  assign bus.io_inpr    = inpr_q;
  assign bus.io_fgiset  = fgiset_q;
  assign bus.io_fgoset  = fgoset_q;
  assign bus.io_overrun = overrun_q;
  assign bus.io_framerr = framerr_q;
endmodule

// File: tb/tb_cor_term.sv
// Bench for cor_term: a frame-level reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_cor_term;
  localparam int CPB       = 16;
  localparam int RX_DECIDE = 2 + CPB/2 + 9*CPB;   // cycle of the stop-bit decision after rxd falls

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  cor_term_if bus();

  cor_term #(.CLKS_PER_BIT(CPB)) dut (
    .io_clock  (clk),
    .io_reset_n(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference model: frames are recorded when sent; outcomes follow the 8N1 rules directly
  typedef struct { int t0; logic [7:0] data; logic stop; logic glitch; } rx_rec_t;
  rx_rec_t    rx_q[$];
  logic [7:0] m_inpr   = 8'h00;
  logic       m_fgiset = 1'b0;
  logic       m_over   = 1'b0;
  logic       m_frm    = 1'b0;
  int         tx_phase = 0;      // 0 idle, 1 sending frame, 2 done and awaiting flag
  int         tx_t1    = 0;
  logic [7:0] tx_data  = 8'h00;
  bit         chk_en   = 1'b0;

  function automatic logic exp_txd(input int k);
    int b;
    if (tx_phase != 1) return 1'b1;
    b = (k - tx_t1 - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return tx_data[b-1];
    return 1'b1;
  endfunction

  task automatic model_step(input int k);
    logic       nf = 1'b0;
    logic       so = 1'b0;
    logic       sf = 1'b0;
    logic [7:0] ni = m_inpr;
    foreach (rx_q[i]) begin
      if (!rx_q[i].glitch && rx_q[i].t0 + RX_DECIDE == k) begin
        if (!rx_q[i].stop)   sf = 1'b1;
        else if (!bus.io_fgi) begin ni = rx_q[i].data; nf = 1'b1; end
        else                 so = 1'b1;
      end
    end
    while (rx_q.size() > 0 && rx_q[0].t0 + RX_DECIDE <= k) void'(rx_q.pop_front());
    m_over   = so | (m_over & ~bus.io_clrerr);
    m_frm    = sf | (m_frm & ~bus.io_clrerr);
    m_inpr   = ni;
    m_fgiset = nf;
    case (tx_phase)
      0: if (!bus.io_fgo) begin tx_phase = 1; tx_t1 = k; tx_data = bus.io_outr; end
      1: if (k == tx_t1 + 10*CPB) tx_phase = 2;
      default: if (bus.io_fgo) tx_phase = 0;
    endcase
  endtask

  always @(negedge clk) begin
    logic [12:0] got, want;
    if (!rst_n) begin
      rx_q.delete();
      m_inpr = 8'h00; m_fgiset = 1'b0; m_over = 1'b0; m_frm = 1'b0; tx_phase = 0;
    end
    if (chk_en) begin
      want = {exp_txd(cyc), m_inpr, m_fgiset, (tx_phase == 2 && cyc == tx_t1 + 1 + 10*CPB), m_over, m_frm};
      got  = {bus.io_txd, bus.io_inpr, bus.io_fgiset, bus.io_fgoset, bus.io_overrun, bus.io_framerr};
      chk("outputs{txd,inpr,fgiset,fgoset,ovr,frm}", got, want);
    end
    if (rst_n) model_step(cyc);
  end

  int fgiset_cnt = 0, fgoset_cnt = 0, last_fgiset = -1, last_fgoset = -1;
  always @(negedge clk) begin
    if (bus.io_fgiset === 1'b1) begin fgiset_cnt++; last_fgiset = cyc; end
    if (bus.io_fgoset === 1'b1) begin fgoset_cnt++; last_fgoset = cyc; end
  end

  task automatic wait_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input bit clr, output int t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clk); #1;
    t0 = cyc;
    rx_q.push_back('{cyc, d, stop, 1'b0});
    for (int b = 0; b < 10; b++) begin
      bus.io_rxd = bits[b];
      for (int j = 0; j < CPB; j++) begin
        @(posedge clk); #1;
        if (clr) bus.io_clrerr = (cyc == t0 + RX_DECIDE);
      end
    end
    bus.io_rxd = 1'b1;
  endtask

  task automatic rx_glitch();
    @(posedge clk); #1;
    rx_q.push_back('{cyc, 8'h00, 1'b1, 1'b1});
    bus.io_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.io_rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 bus.io_clrerr = 1'b1;
    @(posedge clk); #1 bus.io_clrerr = 1'b0;
  endtask

  task automatic tx_send_sample(input logic [7:0] d, output logic [9:0] seq, output int t1);
    @(posedge clk); #1;
    bus.io_outr = d;
    bus.io_fgo  = 1'b0;
    t1 = cyc;
    for (int b = 0; b < 10; b++) begin
      wait_neg(t1 + 1 + CPB*b + CPB/2);
      seq[9-b] = bus.io_txd;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, c0, c1;
    logic [9:0] seq;
    bus.io_rxd = 1'b1; bus.io_fgi = 1'b0; bus.io_outr = 8'h00;
    bus.io_fgo = 1'b1; bus.io_clrerr = 1'b0;
    rst_n = 1'b0;

    // Reset held for three cycles
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset txd", bus.io_txd, 1'b1);
    chk("reset inpr", bus.io_inpr, 8'h00);
    chk("reset fgiset", bus.io_fgiset, 1'b0);
    chk("reset fgoset", bus.io_fgoset, 1'b0);
    chk("reset overrun", bus.io_overrun, 1'b0);
    chk("reset framerr", bus.io_framerr, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Clean reception of 0x41
    rx_frame(8'h41, 1'b1, 1'b0, t0);
    wait_neg(t0 + 165);
    chk("rx41 inpr", bus.io_inpr, 8'h41);
    chk("rx41 fgiset cycle", last_fgiset - t0, 155);
    chk("rx41 fgiset count", fgiset_cnt, 1);

    // Overrun while the processor still holds the character
    bus.io_fgi = 1'b1;
    c0 = fgiset_cnt;
    rx_frame(8'h42, 1'b1, 1'b0, t0);
    wait_neg(t0 + 165);
    chk("ovr inpr held", bus.io_inpr, 8'h41);
    chk("ovr no pulse", fgiset_cnt, c0);
    chk("ovr flag", bus.io_overrun, 1'b1);
    pulse_clr();
    @(negedge clk);
    chk("ovr cleared", bus.io_overrun, 1'b0);
    rx_frame(8'h43, 1'b1, 1'b1, t0);
    wait_neg(t0 + 165);
    chk("ovr set beats clear", bus.io_overrun, 1'b1);
    chk("ovr inpr still", bus.io_inpr, 8'h41);
    pulse_clr();
    bus.io_fgi = 1'b0;

    // Framing error, then a short glitch on the idle line
    c0 = fgiset_cnt;
    rx_frame(8'h33, 1'b0, 1'b0, t0);
    wait_neg(t0 + 170);
    chk("frm flag", bus.io_framerr, 1'b1);
    chk("frm no pulse", fgiset_cnt, c0);
    rx_glitch();
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch no pulse", fgiset_cnt, c0);
    chk("glitch no overrun", bus.io_overrun, 1'b0);
    chk("glitch inpr", bus.io_inpr, 8'h41);
    pulse_clr();
    @(negedge clk);
    chk("frm cleared", bus.io_framerr, 1'b0);

    // Transmit 0x5A, hold the flag low, then send 0x0D
    c1 = fgoset_cnt;
    tx_send_sample(8'h5A, seq, t1);
    chk("tx5A bits", seq, 10'b0010110101);
    wait_neg(t1 + 161 + 20);
    chk("tx5A fgoset cycle", last_fgoset - t1, 161);
    chk("tx5A single frame", fgoset_cnt - c1, 1);
    chk("tx5A line idle", bus.io_txd, 1'b1);
    @(posedge clk); #1 bus.io_fgo = 1'b1;
    tx_send_sample(8'h0D, seq, t1);
    chk("tx0D bits", seq, 10'b0101100001);
    wait_neg(t1 + 163);
    bus.io_fgo = 1'b1;
    chk("tx0D fgoset cycle", last_fgoset - t1, 161);
    repeat (5) @(posedge clk);

    // Reset during data bit 3 of a transmit while a receive is in flight
    c0 = fgiset_cnt;
    c1 = fgoset_cnt;
    fork
      begin
        int tr;
        rx_frame(8'h3C, 1'b1, 1'b0, tr);
      end
      begin
        int tr1;
        @(posedge clk); #1;
        bus.io_outr = 8'h77; bus.io_fgo = 1'b0; tr1 = cyc;
        wait_neg(tr1 + 1 + CPB*4 + 5);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midreset txd", bus.io_txd, 1'b1);
        chk("midreset inpr", bus.io_inpr, 8'h00);
        bus.io_fgo = 1'b1;
        wait_neg(tr1 + 175);
        @(posedge clk); #1 rst_n = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midreset no fgiset", fgiset_cnt, c0);
    chk("midreset no fgoset", fgoset_cnt, c1);
    tx_send_sample(8'h55, seq, t1);
    chk("tx55 bits", seq, 10'b0101010101);
    wait_neg(t1 + 163);
    bus.io_fgo = 1'b1;
    chk("tx55 fgoset cycle", last_fgoset - t1, 161);
    chk("tx55 fgoset count", fgoset_cnt - c1, 1);
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
